// File: rtl/add_seq.sv
// Sequential adder/subtractor that adds one CHUNK-bit slice of the operands per clock.
// Latency: out_valid rises NCH = WIDTH/CHUNK cycles after the accepting edge.
// Backpressure: one operation in flight; in_ready only in IDLE, and the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst_n            - clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   - operand handshake (A, B, carry_in, sub sampled on accept)
//   A, B                  - WIDTH-bit operands
//   carry_in, sub         - sub=0: A+B+carry_in, sub=1: A-B-carry_in
//   out_valid / out_ready - result handshake
//   out                   - WIDTH-bit two's complement result
//   carry_out             - carry out of the MSB (for subtract, 1 = no borrow)
//   overflow              - signed overflow
//   zero, negative        - out == 0, out[WIDTH-1]
module add_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // WIDTH is expected to be an integer multiple of CHUNK.
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // B already conditioned (inverted for subtract)
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic             z_q, z_d;
    logic             n_q, n_d;

    // Datapath for the slice currently selected by idx_q.
    int unsigned      base;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] res_nx;
    logic             last_slice;
    logic             msb_cin;

    always_comb begin
        base      = int'(idx_q) * CHUNK;
        slice_a   = a_q[base +: CHUNK];
        slice_b   = b_q[base +: CHUNK];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};

        res_nx                 = res_q;
        res_nx[base +: CHUNK]  = slice_sum[CHUNK-1:0];

        last_slice = (idx_q == IW'(NCH - 1));

        // Since sum = a ^ b ^ cin per bit, the carry into the MSB can be
        // recovered from the MSB operand bits and the MSB sum bit. This avoids
        // splitting the last slice's adder just to tap its internal carry.
        msb_cin = res_nx[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        co_d    = co_q;
        ov_d    = ov_q;
        z_d     = z_q;
        n_d     = n_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1; the extra borrow removes that +1,
                    // hence the initial carry is carry_in XOR sub.
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = carry_in ^ sub;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                res_d   = res_nx;
                carry_d = slice_sum[CHUNK];
                if (last_slice) begin
                    // Flags are captured once, on entry to DONE, so they stay
                    // stable for the whole time the result is presented.
                    co_d    = slice_sum[CHUNK];
                    ov_d    = msb_cin ^ slice_sum[CHUNK];
                    z_d     = (res_nx == '0);
                    n_d     = res_nx[WIDTH-1];
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            ST_DONE: begin
                // No accept is possible in this cycle: in_ready is low in DONE,
                // so a new operation can start at the earliest one edge later.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = res_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
    assign zero      = z_q;
    assign negative  = n_q;

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq: three configurations (16/4, 32/32, 8/1).
// Expected results are queued at accept time and popped by a monitor on each result handshake.
// Backpressure exercised by holding out_ready low (16-bit) and toggling it randomly (8-bit).
module tb_add_seq;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        of;
        logic        z;
        logic        n;
        int          acc;
    } exp_t;

    localparam int NCHS [3] = '{4, 1, 8};
    localparam int WID  [3] = '{16, 32, 8};

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit, 4-bit chunks
    logic        iv16, ir16, ov16, or16, ci16, sub16, co16, of16, z16, n16;
    logic [15:0] a16, b16, out16;
    // 32-bit, single chunk
    logic        iv32, ir32, ov32, or32, ci32, sub32, co32, of32, z32, n32;
    logic [31:0] a32, b32, out32;
    // 8-bit, 1-bit chunks
    logic        iv8, ir8, ov8, or8, ci8, sub8, co8, of8, z8, n8;
    logic [7:0]  a8, b8, out8;

    add_seq #(.WIDTH(16), .CHUNK(4)) d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .carry_in(ci16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .out(out16),
        .carry_out(co16), .overflow(of16), .zero(z16), .negative(n16));

    add_seq #(.WIDTH(32), .CHUNK(32)) d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
        .carry_in(ci32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .out(out32),
        .carry_out(co32), .overflow(of32), .zero(z32), .negative(n32));

    add_seq #(.WIDTH(8), .CHUNK(1)) d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .carry_in(ci8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .out(out8),
        .carry_out(co8), .overflow(of8), .zero(z8), .negative(n8));

    exp_t sbq [3][$];
    logic pv [3] = '{1'b0, 1'b0, 1'b0};

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic co, of, z, n);
        exp_t e;
        e.res = res; e.co = co; e.of = of; e.z = z; e.n = n; e.acc = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic, unsigned for carry/borrow and
    // signed for overflow.
    function automatic exp_t model(input int w, input logic [31:0] a, b, input logic ci, s);
        exp_t   e;
        longint m  = longint'(1) << w;
        longint ua = longint'(a) & (m - 1);
        longint ub = longint'(b) & (m - 1);
        longint c  = longint'(ci);
        longint r  = s ? (ua - ub - c) : (ua + ub + c);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint sr = s ? (sa - sb - c) : (sa + sb + c);
        longint rm = r & (m - 1);
        e.res = 32'(rm);
        e.co  = s ? (ua >= ub + c) : (r >= m);
        e.of  = (sr < -(m / 2)) || (sr >= m / 2);
        e.z   = (rm == 0);
        e.n   = rm[w-1];
        e.acc = 0;
        return e;
    endfunction

    function automatic logic rdy(input int k);
        case (k)
            0:       return ir16;
            1:       return ir32;
            default: return ir8;
        endcase
    endfunction

    task automatic set_valid(input int k, input logic v);
        case (k)
            0:       iv16 = v;
            1:       iv32 = v;
            default: iv8  = v;
        endcase
    endtask

    task automatic issue(input int k, input logic [31:0] a, b, input logic ci, s,
                         input exp_t e, input bit push);
        int n = 0;
        @(negedge clk);
        while (!rdy(k) && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmp($sformatf("ready_wait inst%0d", k), rdy(k), 1'b1);
        if (!rdy(k)) return;
        case (k)
            0:       begin a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; sub16 = s; end
            1:       begin a32 = a;       b32 = b;       ci32 = ci; sub32 = s; end
            default: begin a8  = a[7:0];  b8  = b[7:0];  ci8  = ci; sub8  = s; end
        endcase
        set_valid(k, 1'b1);
        @(posedge clk);
        #1;
        set_valid(k, 1'b0);
        cmp($sformatf("accepted inst%0d", k), rdy(k), 1'b0);
        if (push) begin
            e.acc = cyc;
            sbq[k].push_back(e);
        end
    endtask

    task automatic mon(input int k, input logic v, r, input logic [31:0] res,
                       input logic co, of, z, n);
        exp_t e;
        if (v && !pv[k]) begin
            if (sbq[k].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid inst%0d actual=1 required=0", k);
            end else begin
                cmp($sformatf("latency inst%0d", k), 32'(cyc - sbq[k][0].acc), 32'(NCHS[k]));
            end
        end
        pv[k] = v;
        if (v && r && sbq[k].size() > 0) begin
            e = sbq[k].pop_front();
            cmp($sformatf("out inst%0d", k), res, e.res);
            cmp($sformatf("carry_out inst%0d", k), 32'(co), 32'(e.co));
            cmp($sformatf("overflow inst%0d", k), 32'(of), 32'(e.of));
            cmp($sformatf("zero inst%0d", k), 32'(z), 32'(e.z));
            cmp($sformatf("negative inst%0d", k), 32'(n), 32'(e.n));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, ov16, or16, {16'h0, out16}, co16, of16, z16, n16);
            mon(1, ov32, or32, out32, co32, of32, z32, n32);
            mon(2, ov8, or8, {24'h0, out8}, co8, of8, z8, n8);
        end
    end

    // Random backpressure on the 8-bit instance.
    always @(posedge clk) begin
        #1;
        or8 = 1'(($urandom_range(0, 3)) != 0);
    end

    // Hand-computed 16-bit vectors: a, b, carry_in, sub -> res, co, of, z, n
    logic [15:0] tv_a   [8] = '{16'hFFFF, 16'h0005, 16'h8000, 16'h1234, 16'h0010, 16'h8000, 16'h0010, 16'hFFFF};
    logic [15:0] tv_b   [8] = '{16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'h0010, 16'h8000, 16'h0010, 16'hFFFF};
    logic        tv_ci  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        tv_s   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] tv_res [8] = '{16'h0000, 16'hFFFE, 16'h7FFF, 16'h5556, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    logic [4:0]  tv_fl  [8] = '{5'b10_10_0, 5'b00_00_1, 5'b11_00_0, 5'b00_00_0,
                                5'b00_00_1, 5'b11_10_0, 5'b10_10_0, 5'b10_00_1};
    // tv_fl = {co, of, z, 1'b0, n}

    initial begin
        int   n;
        logic seen;
        exp_t dummy;
        rst_n = 1'b0;
        iv16 = 0; a16 = 0; b16 = 0; ci16 = 0; sub16 = 0; or16 = 1;
        iv32 = 0; a32 = 0; b32 = 0; ci32 = 0; sub32 = 0; or32 = 1;
        iv8  = 0; a8  = 0; b8  = 0; ci8  = 0; sub8  = 0;
        dummy = mk(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        cmp("rst in_ready16", ir16, 1'b1);
        cmp("rst out_valid16", ov16, 1'b0);
        cmp("rst out16", 32'(out16), 32'h0);
        cmp("rst flags16", {co16, of16, z16, n16}, 4'b0000);
        cmp("rst in_ready32", ir32, 1'b1);
        cmp("rst out_valid8", ov8, 1'b0);

        // Release just after an edge: the very next edge must accept.
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 0x7FFF + 1 with the result held under backpressure.
        or16 = 1'b0;
        issue(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
        n = 0;
        while (!ov16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmp("hold reached_done", ov16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            cmp("hold out", 32'(out16), 32'h8000);
            cmp("hold flags", {co16, of16, z16, n16}, 4'b0101);
            cmp("hold in_ready", ir16, 1'b0);
            cmp("hold out_valid", ov16, 1'b1);
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            iv16 = ~iv16;
        end
        // Release with in_valid high: the handshake edge must not also accept.
        or16 = 1'b1;
        iv16 = 1'b1;
        @(posedge clk);
        #1;
        cmp("release in_ready", ir16, 1'b1);
        cmp("release out_valid", ov16, 1'b0);
        iv16 = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(0, 32'(tv_a[i]), 32'(tv_b[i]), tv_ci[i], tv_s[i],
                  mk(32'(tv_res[i]), tv_fl[i][4], tv_fl[i][3], tv_fl[i][2], tv_fl[i][0]), 1'b1);
        end
        n = 0;
        while (sbq[0].size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end

        // Reset in the middle of BUSY, after two slices.
        issue(0, 32'h1111, 32'h2222, 1'b0, 1'b0, dummy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("abort in_ready", ir16, 1'b1);
        cmp("abort out_valid", ov16, 1'b0);
        cmp("abort out", 32'(out16), 32'h0);
        cmp("abort flags", {co16, of16, z16, n16}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | ov16;
        end
        cmp("abort no_valid", seen, 1'b0);
        issue(0, 32'h00FF, 32'h0F01, 1'b0, 1'b0, mk(32'h1000, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);

        // Randomized operands on the 32/32 and 8/1 configurations.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            logic        rc, rs;
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 32'h7FFFFFFF; rb = 32'h1; rc = 0; rs = 0; end
            issue(1, ra, rb, rc, rs, model(32, ra, rb, rc, rs), 1'b1);
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 32'h80; rb = 32'h1; rc = 1; rs = 1; end
            issue(2, ra, rb, rc, rs, model(8, ra & 32'hFF, rb & 32'hFF, rc, rs), 1'b1);
        end

        n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        cmp("drain inst0", 32'(sbq[0].size()), 32'h0);
        cmp("drain inst1", 32'(sbq[1].size()), 32'h0);
        cmp("drain inst2", 32'(sbq[2].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
